symbol_hist: RTL and testbench
==============================

SYMBOL_HIST -- requirements
Module: symbol_hist

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of symbol/count table slots.
REQ-002 SHALL have parameter WIDTH, default 8: bit width of each symbol and each count.
REQ-003 SHALL have port clock  input  1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port sym_valid  input  1: sym_data is valid this cycle.
REQ-006 SHALL have port sym_data  input  WIDTH: incoming symbol.
REQ-007 SHALL have port sym_last  input  1: final symbol of the frame, qualified by sym_valid.
REQ-008 SHALL have port sym_ready  output  1: block accepts a symbol this cycle.
REQ-009 SHALL have port out_data  output  DEPTH*WIDTH: symbol of slot i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port out_probab  output  DEPTH*WIDTH: count of slot i, same packing as out_data.
REQ-011 SHALL have port out_count  output  $clog2(DEPTH+1): number of occupied slots.
REQ-012 SHALL have port out_valid  output  1: one-cycle pulse; frame histogram present on outputs.
REQ-013 SHALL have port out_overflow  output  1: at least one new symbol was dropped because the table was full.
REQ-014 SHALL have port out_sat  output  1: at least one count saturated during the frame.

Function
REQ-015 SHALL implement states COLLECT, EMIT and CLEAR; sym_ready = (state == COLLECT), decoded combinationally from state.
REQ-016 SHALL accept a symbol when sym_valid && sym_ready, and SHALL ignore sym_data/sym_last otherwise.
REQ-017 SHALL, on acceptance, compare sym_data against occupied slots only (index < current occupancy); on a match, increment that slot's count.
REQ-018 SHALL, on a miss with occupancy < DEPTH, write sym_data into slot[occupancy] with count 1 and increment occupancy, so slots are filled in order of first arrival.
REQ-019 SHALL, on a miss with occupancy == DEPTH, drop the symbol and set a sticky frame overflow flag.
REQ-020 SHALL saturate counts at 2^WIDTH-1 (no wrap) and set a sticky frame saturation flag when an increment is blocked.
REQ-021 SHALL treat symbol 0x00 as an ordinary symbol; empty slots are distinguished only by index >= out_count.
REQ-022 SHALL move COLLECT->EMIT on the edge that accepts a symbol with sym_last=1, with that symbol included in the table.
REQ-023 SHALL, in EMIT, load out_data, out_probab, out_count, out_overflow and out_sat from the table and flags, register out_valid=1, and move to CLEAR.
REQ-024 SHALL, in CLEAR, zero all slots, occupancy and sticky flags, register out_valid=0, and move to COLLECT.
REQ-025 Latency: last symbol accepted at cycle N -> out_valid high at cycle N+2 for exactly one cycle; sym_ready low in N+1 and N+2, high again in N+3.
REQ-026 SHALL hold out_data, out_probab, out_count, out_overflow and out_sat stable from the out_valid cycle until the next EMIT.
REQ-027 SHALL report unoccupied slots as symbol 0 and count 0 on the outputs.
REQ-028 SHALL treat a single-symbol frame (first accepted symbol has sym_last=1) as a normal frame with out_count=1.

Reset
REQ-029 SHALL, while rst=1 and independent of clock, force state to COLLECT and zero the table, occupancy, flags and all outputs; sym_ready SHALL therefore be 1 during reset.
REQ-030 SHALL discard any partial frame in progress when rst asserts; a frame is never emitted from reset.

Verification
REQ-031 Frame 0x41,0x42,0x41,0x43,0x41(last) -> slots 0..2 = 41/42/43; counts 3/1/1; out_count=3; overflow=0; sat=0; slots 3..7 = 0/0.
REQ-032 Frame of symbols 0..8, last on 8 -> slots 0..7 = 0..7, each count 1; out_count=8; out_overflow=1.
REQ-033 Frame of 300 x 0x55, last on the 300th -> slot0 = 55 with count 255; out_sat=1; out_count=1.
REQ-034 sym_valid held high continuously across a frame end -> no acceptance in N+1/N+2; the next symbol is accepted at N+3 and appears as slot0 count 1 of the next frame.
REQ-035 rst pulsed after 0x10,0x10 mid-frame, then frame 0x10(last) -> single out_valid with count 1, out_count=1; no out_valid at or after reset before that.
REQ-036 Frame 0x00,0x00(last) -> slot0 = 00 with count 2; out_count=1.

Source files
------------

// File: rtl/symbol_hist_if.sv
// Symbol stream in and frame histogram out for symbol_hist.
// The master drives symbols and observes the histogram; the slave is the block.
interface symbol_hist_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
);
  logic                       sym_valid;
  logic [WIDTH-1:0]           sym_data;
  logic                       sym_last;
  logic                       sym_ready;
  logic [DEPTH*WIDTH-1:0]     out_data;
  logic [DEPTH*WIDTH-1:0]     out_probab;
  logic [$clog2(DEPTH+1)-1:0] out_count;
  logic                       out_valid;
  logic                       out_overflow;
  logic                       out_sat;

  modport master (
    output sym_valid, sym_data, sym_last,
    input  sym_ready, out_data, out_probab, out_count, out_valid, out_overflow, out_sat
  );

  modport slave (
    input  sym_valid, sym_data, sym_last,
    output sym_ready, out_data, out_probab, out_count, out_valid, out_overflow, out_sat
  );
endinterface

// File: rtl/symbol_hist.sv
// Per-frame symbol histogram: distinct symbols kept in first-arrival order with
// saturating counts, published as a one-cycle snapshot after the last symbol.
module symbol_hist #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input logic          clock,
  input logic          rst,
  symbol_hist_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [CW-1:0]    OCC_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EMIT    = 2'd1,
    CLEAR   = 2'd2
  } state_t;

  state_t                 state_r;
  logic [WIDTH-1:0]       sym_r [DEPTH];
  logic [WIDTH-1:0]       cnt_r [DEPTH];
  logic [CW-1:0]          occ_r;
  logic                   ovf_r;
  logic                   sat_r;
  logic [DEPTH*WIDTH-1:0] out_data_r;
  logic [DEPTH*WIDTH-1:0] out_probab_r;
  logic [CW-1:0]          out_count_r;
  logic                   out_valid_r;
  logic                   out_ovf_r;
  logic                   out_sat_r;

  logic                   ready_s;
  logic                   accept_s;
  logic [DEPTH-1:0]       match_s;
  logic                   hit_s;
  logic [IW-1:0]          hit_idx_s;

  // Handshake decode from the current state.
  always_comb begin
    ready_s  = (state_r == COLLECT);
    accept_s = bus.sym_valid && ready_s;
  end

  // Lookup against occupied slots only; stored symbols are unique so at most one hits.
  always_comb begin
    match_s   = {DEPTH{1'b0}};
    hit_idx_s = {IW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = (CW'(i) < occ_r) && (sym_r[i] == bus.sym_data);
      hit_idx_s  = hit_idx_s | (match_s[i] ? IW'(i) : {IW{1'b0}});
    end
    hit_s = |match_s;
  end

  // Frame FSM, table update and registered histogram outputs.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r      <= COLLECT;
      occ_r        <= {CW{1'b0}};
      ovf_r        <= 1'b0;
      sat_r        <= 1'b0;
      out_data_r   <= {(DEPTH*WIDTH){1'b0}};
      out_probab_r <= {(DEPTH*WIDTH){1'b0}};
      out_count_r  <= {CW{1'b0}};
      out_valid_r  <= 1'b0;
      out_ovf_r    <= 1'b0;
      out_sat_r    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        sym_r[i] <= {WIDTH{1'b0}};
        cnt_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      case (state_r)
        COLLECT: begin
          if (accept_s) begin
            if (hit_s) begin
              if (cnt_r[hit_idx_s] == CNT_MAX) begin
                sat_r <= 1'b1;
              end else begin
                cnt_r[hit_idx_s] <= cnt_r[hit_idx_s] + CNT_ONE;
              end
            end else if (occ_r != OCC_FULL) begin
              sym_r[occ_r[IW-1:0]] <= bus.sym_data;
              cnt_r[occ_r[IW-1:0]] <= CNT_ONE;
              occ_r                <= occ_r + CW'(1);
            end else begin
              ovf_r <= 1'b1;
            end
            if (bus.sym_last) begin
              state_r <= EMIT;
            end
          end
        end
        EMIT: begin
          // Slots past occupancy are already zero, so the snapshot needs no masking.
          for (int i = 0; i < DEPTH; i++) begin
            out_data_r[i*WIDTH +: WIDTH]   <= sym_r[i];
            out_probab_r[i*WIDTH +: WIDTH] <= cnt_r[i];
          end
          out_count_r <= occ_r;
          out_ovf_r   <= ovf_r;
          out_sat_r   <= sat_r;
          out_valid_r <= 1'b1;
          state_r     <= CLEAR;
        end
        CLEAR: begin
          for (int i = 0; i < DEPTH; i++) begin
            sym_r[i] <= {WIDTH{1'b0}};
            cnt_r[i] <= {WIDTH{1'b0}};
          end
          occ_r       <= {CW{1'b0}};
          ovf_r       <= 1'b0;
          sat_r       <= 1'b0;
          out_valid_r <= 1'b0;
          state_r     <= COLLECT;
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= COLLECT;
        end
      endcase
    end
  end

  assign bus.sym_ready    = ready_s;
  assign bus.out_data     = out_data_r;
  assign bus.out_probab   = out_probab_r;
  assign bus.out_count    = out_count_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_overflow = out_ovf_r;
  assign bus.out_sat      = out_sat_r;
endmodule

// File: tb/tb_symbol_hist.sv
// Self-checking bench for symbol_hist: table vectors, hand-written corner
// sequences and random frames against a first-arrival histogram model.
module tb_symbol_hist;
  typedef logic [7:0] byte_q_t[$];

  typedef struct packed {
    logic [63:0] data;
    logic [63:0] prob;
    logic [3:0]  count;
    logic        ovf;
    logic        sat;
  } result_t;

  typedef struct {
    logic [47:0] s;
    int          n;
    result_t     exp;
  } vec_t;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  int   vp_cnt  = 0;

  symbol_hist_if #(.DEPTH(8), .WIDTH(8)) bus ();

  symbol_hist #(.DEPTH(8), .WIDTH(8)) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (bus.out_valid === 1'b1) vp_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic result_t mkres(input logic [63:0] d, input logic [63:0] p,
                                    input int c, input bit o, input bit s);
    result_t r;
    r.data = d; r.prob = p; r.count = 4'(c); r.ovf = o; r.sat = s;
    return r;
  endfunction

  // Reference: distinct symbols in first-arrival order (at most 8), count = occurrences capped at 255.
  function automatic result_t model(input byte_q_t q);
    result_t r;
    logic [7:0] seen[$];
    bit found;
    int occ;
    r = '0;
    foreach (q[k]) begin
      found = 1'b0;
      foreach (seen[j]) if (seen[j] == q[k]) found = 1'b1;
      if (!found) begin
        if (seen.size() < 8) seen.push_back(q[k]);
        else r.ovf = 1'b1;
      end
    end
    r.count = 4'(seen.size());
    foreach (seen[j]) begin
      occ = 0;
      foreach (q[k]) if (q[k] == seen[j]) occ++;
      r.data[j*8 +: 8] = seen[j];
      r.prob[j*8 +: 8] = (occ > 255) ? 8'hFF : occ[7:0];
      if (occ > 255) r.sat = 1'b1;
    end
    return r;
  endfunction

  task automatic send_syms(input byte_q_t q, input bit last);
    int guard;
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clock);
      bus.sym_valid = 1'b1;
      bus.sym_data  = q[k];
      bus.sym_last  = last && (k == q.size() - 1);
      guard = 0;
      while (bus.sym_ready !== 1'b1 && guard < 8) begin
        @(negedge clock);
        guard++;
      end
      if (bus.sym_ready !== 1'b1) chk("accept_timeout", {63'd0, bus.sym_ready}, 64'd1);
      @(posedge clock);
    end
    if (!last) begin
      @(negedge clock);
      bus.sym_valid = 1'b0;
      bus.sym_last  = 1'b0;
    end
  endtask

  // Called right after the edge that accepted the last symbol; checks the N+1..N+3 timing.
  task automatic wait_emit(input bit hold, output result_t act);
    @(negedge clock);
    if (hold) begin
      bus.sym_valid = 1'b1; bus.sym_data = 8'h99; bus.sym_last = 1'b1;
    end else begin
      bus.sym_valid = 1'b0; bus.sym_last = 1'b0;
    end
    chk("ready_n1", {63'd0, bus.sym_ready}, 64'd0);
    chk("valid_n1", {63'd0, bus.out_valid}, 64'd0);
    @(negedge clock);
    chk("valid_n2", {63'd0, bus.out_valid}, 64'd1);
    chk("ready_n2", {63'd0, bus.sym_ready}, 64'd0);
    act.data  = bus.out_data;
    act.prob  = bus.out_probab;
    act.count = bus.out_count;
    act.ovf   = bus.out_overflow;
    act.sat   = bus.out_sat;
    @(negedge clock);
    chk("valid_n3", {63'd0, bus.out_valid}, 64'd0);
    chk("ready_n3", {63'd0, bus.sym_ready}, 64'd1);
  endtask

  task automatic cmp_res(input string name, input result_t act, input result_t exp);
    chk({name, "_data"},  act.data, exp.data);
    chk({name, "_prob"},  act.prob, exp.prob);
    chk({name, "_count"}, {60'd0, act.count}, {60'd0, exp.count});
    chk({name, "_ovf"},   {63'd0, act.ovf}, {63'd0, exp.ovf});
    chk({name, "_sat"},   {63'd0, act.sat}, {63'd0, exp.sat});
  endtask

  initial begin
    vec_t    vecs[4];
    byte_q_t q;
    result_t act;
    int      pulses_before;

    vecs[0].s = 48'h00_41_43_41_42_41; vecs[0].n = 5;
    vecs[0].exp = mkres(64'h0000_0000_0043_4241, 64'h0000_0000_0001_0103, 3, 1'b0, 1'b0);
    vecs[1].s = 48'h00_00_00_00_00_00; vecs[1].n = 2;
    vecs[1].exp = mkres(64'h0, 64'h0000_0000_0000_0002, 1, 1'b0, 1'b0);
    vecs[2].s = 48'h00_00_00_00_00_7F; vecs[2].n = 1;
    vecs[2].exp = mkres(64'h0000_0000_0000_007F, 64'h0000_0000_0000_0001, 1, 1'b0, 1'b0);
    vecs[3].s = 48'h00_00_02_FF_01_FF; vecs[3].n = 4;
    vecs[3].exp = mkres(64'h0000_0000_0002_01FF, 64'h0000_0000_0001_0102, 3, 1'b0, 1'b0);

    bus.sym_valid = 1'b0; bus.sym_data = 8'h00; bus.sym_last = 1'b0;
    @(negedge clock);
    chk("rst_ready", {63'd0, bus.sym_ready}, 64'd1);
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_count", {60'd0, bus.out_count}, 64'd0);
    chk("rst_data",  bus.out_data, 64'd0);
    @(negedge clock);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      q = {};
      for (int k = 0; k < vecs[v].n; k++) q.push_back(vecs[v].s[k*8 +: 8]);
      send_syms(q, 1'b1);
      wait_emit(1'b0, act);
      cmp_res($sformatf("vec%0d", v), act, vecs[v].exp);
    end

    // Outputs hold across a partially collected frame.
    send_syms('{8'h01, 8'h02}, 1'b0);
    chk("hold_data", bus.out_data, vecs[3].exp.data);
    chk("hold_prob", bus.out_probab, vecs[3].exp.prob);
    send_syms('{8'h03}, 1'b1);
    wait_emit(1'b0, act);
    cmp_res("hold_next", act, mkres(64'h0000_0000_0003_0201, 64'h0000_0000_0001_0101, 3, 1'b0, 1'b0));

    q = {};
    for (int k = 0; k < 9; k++) q.push_back(8'(k));
    send_syms(q, 1'b1);
    wait_emit(1'b0, act);
    cmp_res("overflow", act, mkres(64'h0706_0504_0302_0100, 64'h0101_0101_0101_0101, 8, 1'b1, 1'b0));

    q = {};
    for (int k = 0; k < 300; k++) q.push_back(8'h55);
    send_syms(q, 1'b1);
    wait_emit(1'b0, act);
    cmp_res("saturate", act, mkres(64'h55, 64'hFF, 1, 1'b0, 1'b1));

    // sym_valid stays high through the frame boundary.
    send_syms('{8'h12, 8'h34}, 1'b1);
    wait_emit(1'b1, act);
    cmp_res("b2b_first", act, mkres(64'h3412, 64'h0101, 2, 1'b0, 1'b0));
    @(posedge clock);
    wait_emit(1'b0, act);
    cmp_res("b2b_second", act, mkres(64'h99, 64'h01, 1, 1'b0, 1'b0));

    // Reset mid-frame discards the partial frame.
    send_syms('{8'h10, 8'h10}, 1'b0);
    @(negedge clock);
    rst = 1'b1;
    pulses_before = vp_cnt;
    #1;
    chk("midrst_ready", {63'd0, bus.sym_ready}, 64'd1);
    chk("midrst_data",  bus.out_data, 64'd0);
    chk("midrst_count", {60'd0, bus.out_count}, 64'd0);
    @(negedge clock);
    chk("midrst_valid", {63'd0, bus.out_valid}, 64'd0);
    rst = 1'b0;
    send_syms('{8'h10}, 1'b1);
    wait_emit(1'b0, act);
    cmp_res("after_rst", act, mkres(64'h10, 64'h01, 1, 1'b0, 1'b0));
    chk("after_rst_pulses", 64'(vp_cnt - pulses_before), 64'd1);

    for (int f = 0; f < 25; f++) begin
      int len;
      len = $urandom_range(1, 24);
      q = {};
      for (int k = 0; k < len; k++)
        q.push_back((f % 5 == 4) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 11)));
      send_syms(q, 1'b1);
      wait_emit(1'b0, act);
      cmp_res($sformatf("rand%0d", f), act, model(q));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
